branch_redirect_ctrl: RTL and testbench
=======================================

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-002 The block SHALL have the port resetn, input, 1 bit: the reset, asynchronous and active-low.
REQ-003 The block SHALL have the port ex_branch_valid, input, 1 bit: a branch/jump is resolved in EX this cycle.
REQ-004 The block SHALL have the port ex_branch_taken, input, 1 bit: the resolved branch is taken (b-type taken, j/jal, jr/jalr).
REQ-005 The block SHALL have the port ex_branch_target, input, 32 bits: the resolved target PC.
REQ-006 The block SHALL have the port ds_fetched, input, 1 bit: the delay-slot instruction of the EX branch has been fetched.
REQ-007 The block SHALL have the port stall, input, 1 bit: global pipeline stall; while it is high, EX outputs are not valid for sampling.
REQ-008 The block SHALL have the port if_ready, input, 1 bit: fetch accepts the redirect this cycle.
REQ-009 The block SHALL have the port exc_flush, input, 1 bit: exception/eret flush; it has highest priority.
REQ-010 The block SHALL have the port redirect_valid, output, 1 bit: the redirect request to fetch.
REQ-011 The block SHALL have the port redirect_pc, output, 32 bits: the redirect target.
REQ-012 The block SHALL have the port flush_if, output, 1 bit: kill the wrong-path instruction(s) fetched after the delay slot.
REQ-013 The block SHALL have the port busy, output, 1 bit: a redirect is pending (state != IDLE).
REQ-014 The block SHALL have the port conflict, output, 1 bit: sticky flag meaning a branch was resolved while a redirect was pending.
REQ-015 The block SHALL have the port branch_cnt, output, 16 bits: resolved-branch counter, saturating.
REQ-016 The block SHALL have the port taken_cnt, output, 16 bits: taken-branch counter, saturating.

Function
REQ-017 The block SHALL implement a three-state FSM with states IDLE, WAIT_DS and ISSUE.
REQ-018 The block SHALL define a sample event as ex_branch_valid=1 and stall=0 and exc_flush=0; no other cycle is sampled.
REQ-019 In IDLE, on a sample event with ex_branch_taken=1, the block SHALL latch ex_branch_target into redirect_pc, then go to ISSUE if ds_fetched=1, else to WAIT_DS.
REQ-020 In IDLE, on a sample event with ex_branch_taken=0, the block SHALL stay in IDLE and produce no redirect.
REQ-021 In WAIT_DS, the block SHALL hold redirect_pc and go to ISSUE in the first cycle with ds_fetched=1, independent of stall.
REQ-022 In ISSUE, the block SHALL drive redirect_valid=1 and flush_if=1, and SHALL hold redirect_pc stable until if_ready=1.
REQ-023 In ISSUE, in the cycle with if_ready=1, the block SHALL return to IDLE, so redirect_valid=0 on the next cycle.
REQ-024 The block SHALL drive redirect_valid and flush_if only in ISSUE, as registered outputs decoded from state, so the minimum latency is 1 cycle from sample to redirect_valid.
REQ-025 The block SHALL drive busy=1 exactly in WAIT_DS and ISSUE.
REQ-026 exc_flush=1 in any state SHALL force IDLE on the next edge and drop the pending target; on that next cycle redirect_valid=0 and flush_if=0.
REQ-027 When exc_flush and ex_branch_valid occur in the same cycle, exc_flush SHALL win: the branch is not counted and no state change occurs except to IDLE.
REQ-028 A sample event in WAIT_DS or ISSUE SHALL be ignored for the FSM, SHALL set conflict=1 (sticky until reset) and SHALL still be counted.
REQ-029 On every sample event, branch_cnt SHALL increment by 1, saturating at 16'hFFFF.
REQ-030 On every sample event with ex_branch_taken=1, taken_cnt SHALL increment by 1, saturating at 16'hFFFF.
REQ-031 redirect_pc SHALL be updated only on an IDLE taken sample and SHALL otherwise retain its value, including after return to IDLE.

Reset
REQ-032 resetn=0 SHALL asynchronously force state to IDLE, and set redirect_valid, flush_if, busy and conflict to 0, redirect_pc to 32'h0, and branch_cnt and taken_cnt to 16'h0.
REQ-033 Reset asserted mid-operation (WAIT_DS or ISSUE) SHALL abandon the pending redirect; after release the block SHALL be in IDLE with no redirect.

Verification
REQ-034 The bench SHALL cover: taken, ds_fetched=1, target 32'hBFC00100, if_ready=1 -> redirect_valid=1 and redirect_pc=32'hBFC00100 for exactly 1 cycle, 1 cycle after the sample; taken_cnt=1.
REQ-035 The bench SHALL cover: taken with ds_fetched=0 for 3 cycles, then 1 -> busy=1 for 4 cycles, then redirect_valid=1 in the cycle after ds_fetched rises.
REQ-036 The bench SHALL cover: ISSUE with if_ready=0 for 5 cycles -> redirect_valid and flush_if held at 1 and redirect_pc stable; IDLE after if_ready=1.
REQ-037 The bench SHALL cover: exc_flush in WAIT_DS, and exc_flush coincident with a taken branch -> IDLE next cycle, redirect_valid never asserted, counters unchanged.
REQ-038 The bench SHALL cover: a second sample while busy -> conflict=1, branch_cnt incremented, original redirect_pc delivered unchanged; conflict stays 1 until reset.
REQ-039 The bench SHALL cover: preload via 65535 samples with ex_branch_taken=1, then 1 more -> branch_cnt=taken_cnt=16'hFFFF (saturated); a stalled branch is not counted; resetn pulse in ISSUE -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Turns a branch/jump resolved in EX into a single redirect request towards
// fetch. The redirect waits until the branch's delay-slot instruction has
// been fetched. It is then held until fetch accepts it. An exception or eret
// flush overrides everything and drops any pending redirect.
//
// Ports
//   clk               single clock, all state on its rising edge
//   resetn            asynchronous active-low reset
//   ex_branch_valid   a branch/jump is resolved in EX this cycle
//   ex_branch_taken   the resolved branch is taken
//   ex_branch_target  resolved target PC
//   ds_fetched        delay-slot instruction of the EX branch has been fetched
//   stall             global pipeline stall (EX outputs not valid while high)
//   if_ready          fetch accepts the redirect this cycle
//   exc_flush         exception/eret flush, highest priority
//   redirect_valid    redirect request to fetch (registered, ISSUE only)
//   redirect_pc       redirect target
//   flush_if          kill wrong-path fetches after the delay slot
//   busy              a redirect is pending (WAIT_DS or ISSUE)
//   conflict          sticky: a branch was resolved while a redirect was pending
//   branch_cnt        saturating count of resolved branches
//   taken_cnt         saturating count of taken branches
//   fsm_state         current FSM state, for observation only
//
// Handshake (redirect_valid / if_ready): a redirect transfers in a cycle
// where both are high. While redirect_valid is high and if_ready is low,
// redirect_pc and flush_if stay stable. redirect_valid never drops without
// a transfer unless exc_flush or resetn intervenes.
// ---------------------------------------------------------------------------
module branch_redirect_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_branch_valid,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic        ds_fetched,
    input  logic        stall,
    input  logic        if_ready,
    input  logic        exc_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_if,
    output logic        busy,
    output logic        conflict,
    output logic [15:0] branch_cnt,
    output logic [15:0] taken_cnt,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_DS = 2'd1;
    localparam logic [1:0] ISSUE   = 2'd2;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       sample;
    logic       launch;

    // The EX branch fields are only trusted when nothing is stalling or
    // flushing the pipeline.
    assign sample = ex_branch_valid & ~stall & ~exc_flush;

    // A new redirect starts only from IDLE. Samples that arrive while busy
    // are counted and flagged, but they do not disturb the pending redirect.
    assign launch = sample & ex_branch_taken & (state == IDLE);

    always_comb begin
        state_nxt = state;
        if (exc_flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        state_nxt = ds_fetched ? ISSUE : WAIT_DS;
                    end
                end
                WAIT_DS: begin
                    // The delay slot arrives from fetch, so stall does not
                    // hold back this transition.
                    if (ds_fetched) begin
                        state_nxt = ISSUE;
                    end
                end
                ISSUE: begin
                    if (if_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state decode. They therefore
    // equal a decode of the state register, without any combinational path
    // from the inputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            flush_if       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_nxt;
            redirect_valid <= (state_nxt == ISSUE);
            flush_if       <= (state_nxt == ISSUE);
            busy           <= (state_nxt != IDLE);
        end
    end

    // The target is captured only when a redirect launches. It is kept
    // afterwards, even across a flush or a return to IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redirect_pc <= 32'h0;
        end else if (launch) begin
            redirect_pc <= ex_branch_target;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            conflict <= 1'b0;
        end else if (sample && (state != IDLE)) begin
            conflict <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            branch_cnt <= 16'h0;
            taken_cnt  <= 16'h0;
        end else if (sample) begin
            if (branch_cnt != CNT_MAX) begin
                branch_cnt <= branch_cnt + 16'd1;
            end
            if (ex_branch_taken && (taken_cnt != CNT_MAX)) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
`timescale 1ns/1ps
// Testbench for branch_redirect_ctrl.
// - A reference model tracks a pending redirect record at transaction level.
// - Each launched redirect pushes its target onto exp_q.
// - A monitor pops exp_q on each accepted redirect and compares the target.
// - A per-cycle checker compares all outputs against the model.
// - Directed sequences check the specific behaviours against constants.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ex_branch_valid = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic [31:0] ex_branch_target = 32'h0;
    logic        ds_fetched = 1'b0;
    logic        stall = 1'b0;
    logic        if_ready = 1'b0;
    logic        exc_flush = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if;
    logic        busy;
    logic        conflict;
    logic [15:0] branch_cnt;
    logic [15:0] taken_cnt;
    logic [1:0]  fsm_state;

    int checks = 0;
    int failures = 0;
    bit en_cyc = 1'b0;

    logic [31:0] exp_q[$];

    // Reference model: one optional pending redirect record.
    bit          m_pend = 1'b0;
    bit          m_ds = 1'b0;
    logic [31:0] m_pc = 32'h0;
    bit          m_conflict = 1'b0;
    logic [15:0] m_bcnt = 16'h0;
    logic [15:0] m_tcnt = 16'h0;

    logic [67:0] dut_vec;
    logic [67:0] mdl_vec;
    assign dut_vec = {redirect_valid, flush_if, busy, conflict, redirect_pc, branch_cnt, taken_cnt};
    assign mdl_vec = {(m_pend && m_ds), (m_pend && m_ds), m_pend, m_conflict, m_pc, m_bcnt, m_tcnt};

    branch_redirect_ctrl dut (
        .clk              (clk),
        .resetn           (resetn),
        .ex_branch_valid  (ex_branch_valid),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .ds_fetched       (ds_fetched),
        .stall            (stall),
        .if_ready         (if_ready),
        .exc_flush        (exc_flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush_if         (flush_if),
        .busy             (busy),
        .conflict         (conflict),
        .branch_cnt       (branch_cnt),
        .taken_cnt        (taken_cnt),
        .fsm_state        (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- compare helper ----------------
    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_pend = 1'b0;
                m_ds = 1'b0;
                m_pc = 32'h0;
                m_conflict = 1'b0;
                m_bcnt = 16'h0;
                m_tcnt = 16'h0;
                exp_q.delete();
            end else begin
                bit smp;
                smp = ex_branch_valid && !stall && !exc_flush;
                if (smp) begin
                    if (m_bcnt < 16'hFFFF) m_bcnt = m_bcnt + 16'd1;
                    if (ex_branch_taken && m_tcnt < 16'hFFFF) m_tcnt = m_tcnt + 16'd1;
                    if (m_pend) m_conflict = 1'b1;
                end
                if (exc_flush) begin
                    // A redirect accepted in this same cycle counts as delivered.
                    if (m_pend && !(m_ds && if_ready) && exp_q.size() > 0)
                        void'(exp_q.pop_back());
                    m_pend = 1'b0;
                    m_ds = 1'b0;
                end else if (m_pend) begin
                    if (m_ds) begin
                        if (if_ready) m_pend = 1'b0;
                    end else if (ds_fetched) begin
                        m_ds = 1'b1;
                    end
                end else if (smp && ex_branch_taken) begin
                    m_pend = 1'b1;
                    m_ds = ds_fetched;
                    m_pc = ex_branch_target;
                    exp_q.push_back(ex_branch_target);
                end
            end
        end
    end

    // ---------------- monitor: accepted redirects ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && redirect_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL redirect_unexpected: got pc %h expected no redirect at %0t", redirect_pc, $time);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("redirect_pc_delivered", {36'h0, redirect_pc}, {36'h0, e});
                end
            end
        end
    end

    // ---------------- per-cycle output check ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (en_cyc) chk("cycle_outputs", dut_vec, mdl_vec);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] t2_pc;
        logic [31:0] a_pc;
        logic [31:0] c_pc;
        logic [15:0] exp_b;
        logic [15:0] exp_t;

        exp_b = 16'd0;
        exp_t = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", dut_vec, 68'h0);
        resetn = 1'b1;
        en_cyc = 1'b1;
        tick();

        // Taken branch, delay slot already fetched, fetch ready.
        ex_branch_valid = 1'b1; ex_branch_taken = 1'b1;
        ex_branch_target = 32'hBFC00100; ds_fetched = 1'b1; if_ready = 1'b1;
        tick();
        exp_b++; exp_t++;
        ex_branch_valid = 1'b0;
        chk("t1_redirect_valid", {67'h0, redirect_valid}, 68'h1);
        chk("t1_redirect_pc", {36'h0, redirect_pc}, {36'h0, 32'hBFC00100});
        chk("t1_taken_cnt", {52'h0, taken_cnt}, 68'h1);
        tick();
        chk("t1_single_cycle", {66'h0, redirect_valid, busy}, 68'h0);

        // Delay slot late by three cycles, then fetch holds off five cycles.
        if_ready = 1'b0;
        t2_pc = $urandom;
        ex_branch_valid = 1'b1; ex_branch_taken = 1'b1;
        ex_branch_target = t2_pc; ds_fetched = 1'b0;
        tick();
        exp_b++; exp_t++;
        ex_branch_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_busy_wait", {66'h0, busy, redirect_valid}, 68'h2);
            if (i == 3) ds_fetched = 1'b1;
            tick();
        end
        ds_fetched = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold", {34'h0, redirect_valid, flush_if, redirect_pc}, {34'h0, 2'b11, t2_pc});
            tick();
        end
        chk("t3_still_issue", {67'h0, redirect_valid}, 68'h1);
        if_ready = 1'b1;
        tick();
        chk("t3_idle_after_ready", {66'h0, redirect_valid, busy}, 68'h0);

        // Flush while waiting for the delay slot.
        if_ready = 1'b0;
        ex_branch_valid = 1'b1; ex_branch_taken = 1'b1;
        ex_branch_target = $urandom; ds_fetched = 1'b0;
        tick();
        exp_b++; exp_t++;
        ex_branch_valid = 1'b0; exc_flush = 1'b1; ds_fetched = 1'b1;
        tick();
        chk("t4_flush_wait_ds", {66'h0, busy, redirect_valid}, 68'h0);
        exc_flush = 1'b0; ds_fetched = 1'b0;
        tick();
        chk("t4_no_redirect", {65'h0, busy, redirect_valid, flush_if}, 68'h0);
        chk("t4_counts", {36'h0, branch_cnt, taken_cnt}, {36'h0, exp_b, exp_t});

        // Flush coincident with a taken branch.
        ex_branch_valid = 1'b1; ex_branch_taken = 1'b1;
        ex_branch_target = $urandom; ds_fetched = 1'b1; exc_flush = 1'b1;
        tick();
        chk("t4b_flush_wins", {65'h0, busy, redirect_valid, flush_if}, 68'h0);
        chk("t4b_not_counted", {36'h0, branch_cnt, taken_cnt}, {36'h0, exp_b, exp_t});
        ex_branch_valid = 1'b0; exc_flush = 1'b0;
        tick();
        chk("t4b_no_redirect", {66'h0, busy, redirect_valid}, 68'h0);

        // Second branch resolved while a redirect is pending.
        a_pc = $urandom;
        ex_branch_valid = 1'b1; ex_branch_taken = 1'b1;
        ex_branch_target = a_pc; ds_fetched = 1'b1; if_ready = 1'b0;
        tick();
        exp_b++; exp_t++;
        ex_branch_target = ~a_pc;
        tick();
        exp_b++; exp_t++;
        ex_branch_valid = 1'b0;
        chk("t5_conflict", {67'h0, conflict}, 68'h1);
        chk("t5_branch_cnt", {52'h0, branch_cnt}, {52'h0, exp_b});
        chk("t5_pc_kept", {35'h0, redirect_valid, redirect_pc}, {35'h0, 1'b1, a_pc});
        if_ready = 1'b1;
        tick();
        tick();
        chk("t5_conflict_sticky", {66'h0, conflict, busy}, 68'h2);

        // Stalled branch is not sampled.
        ex_branch_valid = 1'b1; ex_branch_taken = 1'b1; stall = 1'b1;
        tick();
        chk("t6_stall_not_counted", {35'h0, busy, branch_cnt, taken_cnt}, {35'h0, 1'b0, exp_b, exp_t});
        ex_branch_valid = 1'b0; stall = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            ex_branch_valid  = ($urandom_range(0, 2) == 0);
            ex_branch_taken  = $urandom_range(0, 1);
            ex_branch_target = $urandom;
            ds_fetched       = ($urandom_range(0, 3) != 0);
            stall            = ($urandom_range(0, 4) == 0);
            if_ready         = ($urandom_range(0, 2) != 0);
            exc_flush        = ($urandom_range(0, 15) == 0);
            tick();
        end
        ex_branch_valid = 1'b0; stall = 1'b0; exc_flush = 1'b0;
        ds_fetched = 1'b1; if_ready = 1'b1;
        repeat (4) tick();
        chk("random_drained", {36'h0, 32'(exp_q.size())}, 68'h0);

        // Saturation: 65535 taken samples, then one more.
        en_cyc = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        ex_branch_valid = 1'b1; ex_branch_taken = 1'b1;
        ex_branch_target = 32'h80000040; ds_fetched = 1'b1; if_ready = 1'b1;
        repeat (65535) tick();
        chk("sat_preload", {36'h0, branch_cnt, taken_cnt}, {36'h0, 32'hFFFFFFFF});
        tick();
        chk("sat_hold", {36'h0, branch_cnt, taken_cnt}, {36'h0, 32'hFFFFFFFF});
        ex_branch_valid = 1'b0;
        repeat (2) tick();
        en_cyc = 1'b1;

        // Asynchronous reset while in ISSUE.
        c_pc = $urandom | 32'h1;
        if_ready = 1'b0;
        ex_branch_valid = 1'b1; ex_branch_taken = 1'b1;
        ex_branch_target = c_pc; ds_fetched = 1'b1;
        tick();
        ex_branch_valid = 1'b0;
        chk("rst_pre_issue", {35'h0, redirect_valid, redirect_pc}, {35'h0, 1'b1, c_pc});
        #1 resetn = 1'b0;
        #1;
        chk("rst_async_clear", dut_vec, 68'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        if_ready = 1'b1;
        tick();
        chk("rst_release_idle", {66'h0, busy, redirect_valid}, 68'h0);
        tick();
        chk("final_queue_empty", {36'h0, 32'(exp_q.size())}, 68'h0);

        en_cyc = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
